l1_thresh_wb_master: RTL and testbench
======================================

L1_THRESH_WB_MASTER -- requirements
Module: l1_thresh_wb_master

Interface
REQ-001 Parameter NBEAMS, default 2, number of beams addressable (1..256).
REQ-002 Parameter THR_BASE, default 13'h0800, word address base of threshold bank; beam b at THR_BASE + 4*b.
REQ-003 Parameter SUB_BASE, default 13'h0A00, base of subthreshold bank; beam b at SUB_BASE + 4*b.
REQ-004 Parameter CTL_ADR, default 13'h1800, control register; write 32'h2 = apply, bit 1 reads 1 while apply pending.
REQ-005 Parameter TIMEOUT, default 255, max cycles waiting for wb_ack_i per transaction.
REQ-006 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-007 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-008 req_valid_i  in  1  update request valid.
REQ-009 req_ready_o  out  1  request accepted when valid & ready.
REQ-010 req_beam_i  in  8  beam index.
REQ-011 req_thr_i  in  32  threshold value.
REQ-012 req_sub_i  in  32  subthreshold value.
REQ-013 req_apply_i  in  1  1 = follow writes with apply and poll.
REQ-014 done_o  out  1  one-cycle pulse, request completed OK.
REQ-015 err_o  out  1  one-cycle pulse, request aborted (timeout, bad beam).
REQ-016 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_sel_o out 4; wb_adr_o out 13; wb_dat_o out 32  Wishbone classic initiator.
REQ-017 wb_ack_i  in  1; wb_dat_i  in  32  Wishbone responder returns.

Function
REQ-018 States IDLE, WR_THR, WR_SUB, WR_CTL, RD_CTL, FIN; req_ready_o SHALL be 1 only in IDLE.
REQ-019 Accept registers beam/thr/sub/apply; next cycle SHALL enter WR_THR with cyc=stb=we=1, sel=4'hF, adr=THR_BASE+4*beam, dat=thr.
REQ-020 Each transaction SHALL hold cyc/stb/adr/dat/we stable until the cycle wb_ack_i=1 is sampled; cyc/stb SHALL drop the following cycle for exactly one idle cycle before the next transaction.
REQ-021 Ack in WR_THR -> WR_SUB (adr=SUB_BASE+4*beam, dat=sub); ack in WR_SUB -> WR_CTL if apply else FIN.
REQ-022 WR_CTL writes 32'h2 to CTL_ADR; on ack -> RD_CTL (we=0, sel=4'h0, dat=0).
REQ-023 RD_CTL: on ack, wb_dat_i[1]=0 -> FIN; =1 -> reissue read after one idle cycle; max 16 reads, 17th pending read -> error.
REQ-024 FIN SHALL pulse done_o one cycle, return to IDLE next cycle.
REQ-025 Timeout counter SHALL reset at each transaction start; TIMEOUT cycles without ack -> drop cyc/stb, pulse err_o, IDLE.
REQ-026 req_beam_i >= NBEAMS at accept SHALL skip all bus activity and pulse err_o the cycle after accept.
REQ-027 wb_ack_i while cyc=0 SHALL be ignored; done_o and err_o never both high.
REQ-028 Address arithmetic SHALL be 13-bit, wrap modulo 2^13, no error on wrap.

Reset
REQ-029 While wb_rst_ni=0: state IDLE, all Wishbone outputs 0, req_ready_o=0, done_o=err_o=0, counters 0.
REQ-030 req_ready_o SHALL rise the first cycle after reset deassertion; reset mid-transaction SHALL drop cyc immediately with no done/err pulse.

Structure
REQ-031 State enum, default addresses, and control apply/pending bit positions SHALL live in shared package l1_trig_pkg.
REQ-032 One sub-module, wb_xact_timer (load/run/expire counter), SHALL implement timeout; the FSM stays in top level.

Verification
REQ-033 beam 0, thr 5000, sub 4000, apply 0, responder ack at 2 cycles -> writes 0x0800=5000, 0x0A00=4000, done_o once, no CTL access.
REQ-034 beam 1, thr 5001, sub 300, apply 1, CTL reads pending twice then clear -> writes 0x0804, 0x0A04, 0x1800=2, three reads, done_o.
REQ-035 Responder never acks -> cyc held exactly TIMEOUT cycles, then err_o pulse, req_ready_o=1 next cycle.
REQ-036 beam 2 with NBEAMS=2 -> no cyc assertion, err_o one cycle after accept.
REQ-037 Reset asserted during WR_SUB -> cyc=0 asynchronously, no done/err; next request completes normally.
REQ-038 Back-to-back requests with valid held high -> second accepted only after done_o, one idle bus cycle minimum between transactions.

Source files
------------

// File: rtl/l1_trig_pkg.sv
// l1_trig_pkg -- shared definitions for the L1 trigger threshold loader.
// Holds the master FSM state encoding, the default Wishbone word addresses of
// the threshold/subthreshold banks and the control register, the control
// register bit positions, and the beam address helper.
package l1_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_THR,
    ST_WR_SUB,
    ST_WR_CTL,
    ST_RD_CTL,
    ST_FIN
  } state_t;

  localparam logic [12:0] DEF_THR_BASE = 13'h0800;
  localparam logic [12:0] DEF_SUB_BASE = 13'h0A00;
  localparam logic [12:0] DEF_CTL_ADR  = 13'h1800;

  // Writing the apply bit starts an apply; the same bit reads back as
  // "apply still pending".
  localparam int          CTL_APPLY_BIT   = 1;
  localparam int          CTL_PENDING_BIT = 1;
  localparam logic [31:0] CTL_APPLY_WORD  = 32'(1) << CTL_APPLY_BIT;

  // Number of control reads allowed while waiting for the apply to clear.
  localparam int          MAX_POLLS = 16;

  // Per-beam register address: base + 4*beam, wrapping modulo 2^13.
  function automatic logic [12:0] beam_adr(input logic [12:0] base,
                                           input logic [7:0]  beam);
    return base + {3'b000, beam, 2'b00};
  endfunction

endpackage

// File: rtl/wb_xact_timer.sv
// wb_xact_timer -- per-transaction acknowledge timeout counter.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   load     restart the count (held while no transaction is on the bus)
//   run      a transaction is on the bus this cycle
//   expired  this is the TIMEOUT-th bus cycle without an acknowledge
module wb_xact_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_reg;

  // Loaded with TIMEOUT-1 before the first bus cycle; reaches zero during
  // the TIMEOUT-th bus cycle of the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CW'(TIMEOUT - 1);
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expired = run && (cnt_reg == '0);

endmodule

// File: rtl/l1_thresh_wb_master.sv
// l1_thresh_wb_master -- loads one beam's threshold and subthreshold into the
// trigger register banks over Wishbone classic, optionally followed by an
// apply command and polling of the control register until the apply clears.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   req_valid_i / req_ready_o    request handshake (ready only when idle)
//   req_beam_i, req_thr_i,
//   req_sub_i, req_apply_i       request payload
//   done_o / err_o               one-cycle completion / abort pulses
//   wb_cyc_o .. wb_dat_o         Wishbone initiator outputs (all registered)
//   wb_ack_i, wb_dat_i           Wishbone responder returns
module l1_thresh_wb_master
  import l1_trig_pkg::*;
#(
  parameter int          NBEAMS   = 2,
  parameter logic [12:0] THR_BASE = DEF_THR_BASE,
  parameter logic [12:0] SUB_BASE = DEF_SUB_BASE,
  parameter logic [12:0] CTL_ADR  = DEF_CTL_ADR,
  parameter int          TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_beam_i,
  input  logic [31:0] req_thr_i,
  input  logic [31:0] req_sub_i,
  input  logic        req_apply_i,
  output logic        done_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [12:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  localparam logic [4:0] LAST_POLL = 5'(MAX_POLLS - 1);

  state_t      state_reg;
  logic        ready_reg;
  logic        done_reg;
  logic        err_reg;
  logic        cyc_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [12:0] adr_reg;
  logic [31:0] dat_reg;
  logic        gap_reg;    // one idle bus cycle before the next transaction
  logic [7:0]  beam_reg;
  logic [31:0] sub_reg;
  logic        apply_reg;
  logic [4:0]  poll_reg;   // control reads completed with apply still pending
  logic        expired;
  logic        bad_beam;
  logic        unused_dat;

  assign bad_beam   = ({1'b0, req_beam_i} >= 9'(NBEAMS));
  assign unused_dat = ^{wb_dat_i[31:CTL_PENDING_BIT+1], wb_dat_i[CTL_PENDING_BIT-1:0]};

  // The timer restarts whenever the bus is idle, so each transaction gets
  // its own full TIMEOUT window.
  wb_xact_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .load    (!cyc_reg),
    .run     (cyc_reg),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= 4'h0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      gap_reg   <= 1'b0;
      beam_reg  <= '0;
      sub_reg   <= '0;
      apply_reg <= 1'b0;
      poll_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (req_valid_i && ready_reg) begin
            ready_reg <= 1'b0;
            beam_reg  <= req_beam_i;
            sub_reg   <= req_sub_i;
            apply_reg <= req_apply_i;
            poll_reg  <= '0;
            if (bad_beam) begin
              state_reg <= ST_FIN;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= ST_WR_THR;
              cyc_reg   <= 1'b1;
              gap_reg   <= 1'b0;
              we_reg    <= 1'b1;
              sel_reg   <= 4'hF;
              adr_reg   <= beam_adr(THR_BASE, req_beam_i);
              dat_reg   <= req_thr_i;
            end
          end
        end

        ST_WR_THR, ST_WR_SUB, ST_WR_CTL, ST_RD_CTL: begin
          if (gap_reg) begin
            // Address/data were already set up when the gap began.
            cyc_reg <= 1'b1;
            gap_reg <= 1'b0;
          end else if (cyc_reg && wb_ack_i) begin
            cyc_reg <= 1'b0;
            case (state_reg)
              ST_WR_THR: begin
                state_reg <= ST_WR_SUB;
                gap_reg   <= 1'b1;
                adr_reg   <= beam_adr(SUB_BASE, beam_reg);
                dat_reg   <= sub_reg;
              end
              ST_WR_SUB: begin
                if (apply_reg) begin
                  state_reg <= ST_WR_CTL;
                  gap_reg   <= 1'b1;
                  adr_reg   <= CTL_ADR;
                  dat_reg   <= CTL_APPLY_WORD;
                end else begin
                  state_reg <= ST_FIN;
                  done_reg  <= 1'b1;
                end
              end
              ST_WR_CTL: begin
                state_reg <= ST_RD_CTL;
                gap_reg   <= 1'b1;
                we_reg    <= 1'b0;
                sel_reg   <= 4'h0;
                dat_reg   <= '0;
                poll_reg  <= '0;
              end
              default: begin
                if (!wb_dat_i[CTL_PENDING_BIT]) begin
                  state_reg <= ST_FIN;
                  done_reg  <= 1'b1;
                end else if (poll_reg == LAST_POLL) begin
                  // Every allowed read still showed the apply pending.
                  state_reg <= ST_FIN;
                  err_reg   <= 1'b1;
                end else begin
                  poll_reg <= poll_reg + 1'b1;
                  gap_reg  <= 1'b1;
                end
              end
            endcase
          end else if (cyc_reg && expired) begin
            cyc_reg   <= 1'b0;
            state_reg <= ST_FIN;
            err_reg   <= 1'b1;
          end
        end

        ST_FIN: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end

        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          cyc_reg   <= 1'b0;
          gap_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign wb_cyc_o    = cyc_reg;
  assign wb_stb_o    = cyc_reg;
  assign wb_we_o     = we_reg;
  assign wb_sel_o    = sel_reg;
  assign wb_adr_o    = adr_reg;
  assign wb_dat_o    = dat_reg;

endmodule

// File: tb/tb_l1_thresh_wb_master.sv
// tb_l1_thresh_wb_master -- directed, table-driven bench for the threshold
// loader. A negedge responder model acknowledges after a programmable number
// of bus cycles, answers control reads with the apply-pending bit for a
// programmable number of reads, logs every acknowledged transaction and
// counts bus-protocol violations.
module tb_l1_thresh_wb_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_beam_i;
  logic [31:0] req_thr_i;
  logic [31:0] req_sub_i;
  logic        req_apply_i;
  logic        done_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [12:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  l1_thresh_wb_master dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_beam_i  (req_beam_i),
    .req_thr_i   (req_thr_i),
    .req_sub_i   (req_sub_i),
    .req_apply_i (req_apply_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_i    (wb_ack_i),
    .wb_dat_i    (wb_dat_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  // ---------------- responder / monitor ----------------
  typedef struct {
    logic [12:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          gap;
  } xact_t;

  xact_t log_q[$];

  // Written only by the stimulus process.
  int ack_delay  = 1;
  bit never_ack  = 1'b0;
  int pend_limit = 0;

  // Written only by the monitor.
  int          ctl_reads  = 0;
  int          done_cnt   = 0;
  int          err_cnt    = 0;
  int          both_viol  = 0;
  int          stab_viol  = 0;
  int          drop_viol  = 0;
  int          hi_len     = 0;
  int          last_hi    = 0;
  int          idle_len   = 100;
  int          cur_gap    = 0;
  logic        prev_cyc   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic [12:0] prev_adr   = '0;
  logic [31:0] prev_dat   = '0;
  logic        prev_we    = 1'b0;
  logic [3:0]  prev_sel   = '0;

  always @(negedge wb_clk_i) begin
    if (done_o && err_o) both_viol++;
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        cur_gap = idle_len;
        hi_len  = 0;
      end else if (prev_ack) begin
        drop_viol++;
      end else if (wb_adr_o !== prev_adr || wb_dat_o !== prev_dat ||
                   wb_we_o !== prev_we || wb_sel_o !== prev_sel || !wb_stb_o) begin
        stab_viol++;
      end
      hi_len++;
      idle_len = 0;
      if (!never_ack && hi_len == ack_delay) begin
        wb_ack_i = 1'b1;
        if (!wb_we_o && wb_adr_o == 13'h1800) begin
          wb_dat_i = (ctl_reads < pend_limit) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD;
          ctl_reads++;
        end else begin
          wb_dat_i = '0;
        end
        log_q.push_back('{wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, cur_gap});
      end else begin
        wb_ack_i = 1'b0;
      end
    end else begin
      if (prev_cyc) last_hi = hi_len;
      idle_len++;
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
    end
    prev_cyc = wb_cyc_o;
    prev_ack = wb_ack_i;
    prev_adr = wb_adr_o;
    prev_dat = wb_dat_o;
    prev_we  = wb_we_o;
    prev_sel = wb_sel_o;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  beam;
    logic [31:0] thr;
    logic [31:0] sub;
    logic        apply;
    int          pend;
    int          dly;
    logic        bad;
    int          exp_n;
    logic [12:0] exp_thr_adr;
    logic [12:0] exp_sub_adr;
    logic        exp_done;
  } vec_t;

  // Present a request at a negedge, hold until accepted, drop valid at the
  // negedge following the accepting edge.
  task automatic send(input logic [7:0] beam, input logic [31:0] thr,
                      input logic [31:0] sub, input logic apply, output bit ok);
    int n;
    @(negedge wb_clk_i);
    req_valid_i = 1'b1;
    req_beam_i  = beam;
    req_thr_i   = thr;
    req_sub_i   = sub;
    req_apply_i = apply;
    n = 0;
    while (!req_ready_o && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    ok = (n < 500);
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
  endtask

  // 1 = done, 2 = err, 0 = neither within the bound.
  task automatic wait_end(input int bound, output int res);
    int n;
    n = 0;
    while (!done_o && !err_o && n < bound) begin
      @(negedge wb_clk_i);
      n++;
    end
    res = done_o ? 1 : (err_o ? 2 : 0);
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    int          base, d0, e0, sv0, dv0, bv0, res, n;
    bit          ok;
    logic [12:0] ea;
    logic        ew;
    logic [3:0]  es;
    logic [31:0] ed;
    base = log_q.size();
    d0 = done_cnt; e0 = err_cnt; sv0 = stab_viol; dv0 = drop_viol; bv0 = both_viol;
    ack_delay  = t.dly;
    pend_limit = ctl_reads + t.pend;
    send(t.beam, t.thr, t.sub, t.apply, ok);
    chk({tag, " accept"}, 32'(ok), 32'd1);
    if (t.bad) begin
      chk({tag, " bad_beam_err_next_cycle"}, 32'(err_o), 32'd1);
      chk({tag, " bad_beam_no_cyc"}, 32'(wb_cyc_o), 32'd0);
    end
    wait_end(2000, res);
    @(negedge wb_clk_i);
    chk({tag, " outcome(1=done,2=err)"}, 32'(res), t.exp_done ? 32'd1 : 32'd2);
    chk({tag, " ready_after_end"}, 32'(req_ready_o), 32'd1);
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), t.exp_done ? 32'd1 : 32'd0);
    chk({tag, " err_pulses"}, 32'(err_cnt - e0), t.exp_done ? 32'd0 : 32'd1);
    n = log_q.size() - base;
    chk({tag, " xact_count"}, 32'(n), 32'(t.exp_n));
    for (int k = 0; k < n && k < t.exp_n; k++) begin
      case (k)
        0:       begin ea = t.exp_thr_adr; ew = 1'b1; es = 4'hF; ed = t.thr;  end
        1:       begin ea = t.exp_sub_adr; ew = 1'b1; es = 4'hF; ed = t.sub;  end
        2:       begin ea = 13'h1800;      ew = 1'b1; es = 4'hF; ed = 32'h2; end
        default: begin ea = 13'h1800;      ew = 1'b0; es = 4'h0; ed = 32'h0; end
      endcase
      chk($sformatf("%s x%0d we/sel/adr", tag, k),
          {14'd0, log_q[base+k].we, log_q[base+k].sel, log_q[base+k].adr}, {14'd0, ew, es, ea});
      chk($sformatf("%s x%0d dat", tag, k), log_q[base+k].dat, ed);
      if (k > 0) chk($sformatf("%s x%0d idle_gap", tag, k), 32'(log_q[base+k].gap), 32'd1);
    end
    chk({tag, " stable_while_waiting"}, 32'(stab_viol - sv0), 32'd0);
    chk({tag, " cyc_drop_after_ack"}, 32'(drop_viol - dv0), 32'd0);
    chk({tag, " done_err_exclusive"}, 32'(both_viol - bv0), 32'd0);
    $display("%s: beam=%0d apply=%0d xacts=%0d result=%s", tag, t.beam, t.apply, n,
             res == 1 ? "done" : (res == 2 ? "err" : "none"));
  endtask

  localparam int NVEC = 8;
  vec_t vecs[NVEC];

  initial begin
    int   base, d0, e0, res, n, early;
    bit   ok;
    vec_t v;

    vecs[0] = '{8'd0,   32'd5000,       32'd4000,       1'b0, 0,  2,   1'b0, 2,  13'h0800, 13'h0A00, 1'b1};
    vecs[1] = '{8'd1,   32'd5001,       32'd300,        1'b1, 2,  1,   1'b0, 6,  13'h0804, 13'h0A04, 1'b1};
    vecs[2] = '{8'd0,   32'hDEAD_BEEF,  32'h1234_5678,  1'b1, 0,  3,   1'b0, 4,  13'h0800, 13'h0A00, 1'b1};
    vecs[3] = '{8'd2,   32'd1,          32'd2,          1'b0, 0,  1,   1'b1, 0,  13'h0000, 13'h0000, 1'b0};
    vecs[4] = '{8'd255, 32'd1,          32'd2,          1'b1, 0,  1,   1'b1, 0,  13'h0000, 13'h0000, 1'b0};
    vecs[5] = '{8'd1,   32'd7,          32'd9,          1'b1, 15, 1,   1'b0, 19, 13'h0804, 13'h0A04, 1'b1};
    vecs[6] = '{8'd1,   32'd7,          32'd9,          1'b1, 16, 1,   1'b0, 19, 13'h0804, 13'h0A04, 1'b0};
    vecs[7] = '{8'd0,   32'hAAAA_5555,  32'h5555_AAAA,  1'b0, 0,  255, 1'b0, 2,  13'h0800, 13'h0A00, 1'b1};

    req_valid_i = 1'b0;
    req_beam_i  = '0;
    req_thr_i   = '0;
    req_sub_i   = '0;
    req_apply_i = 1'b0;
    wb_rst_ni   = 1'b1;
    #1 wb_rst_ni = 1'b0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("reset ready", 32'(req_ready_o), 32'd0);
    chk("reset cyc/stb/we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("reset sel/adr", {15'd0, wb_sel_o, wb_adr_o}, 32'd0);
    chk("reset dat", wb_dat_o, 32'd0);
    chk("reset done/err", {30'd0, done_o, err_o}, 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk("ready_first_cycle_after_reset", 32'(req_ready_o), 32'd1);

    // Table-driven requests
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Responder never acknowledges: cyc held exactly TIMEOUT cycles.
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    never_ack = 1'b1;
    send(8'd0, 32'd1, 32'd2, 1'b0, ok);
    chk("timeout accept", 32'(ok), 32'd1);
    wait_end(400, res);
    @(negedge wb_clk_i);
    chk("timeout outcome(2=err)", 32'(res), 32'd2);
    chk("timeout cyc_high_cycles", 32'(last_hi), 32'd255);
    chk("timeout ready_next_cycle", 32'(req_ready_o), 32'd1);
    chk("timeout err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("timeout no_done", 32'(done_cnt - d0), 32'd0);
    chk("timeout no_acked_xacts", 32'(log_q.size() - base), 32'd0);
    $display("timeout: cyc high %0d cycles, result=%s", last_hi, res == 2 ? "err" : "other");
    never_ack = 1'b0;

    // Reset asserted while the subthreshold write is on the bus.
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    ack_delay = 5;
    send(8'd0, 32'd10, 32'd20, 1'b0, ok);
    n = 0;
    while (!(wb_cyc_o && log_q.size() == base + 1) && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("midreset reached_wr_sub", 32'(n < 100), 32'd1);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk("midreset cyc_async_drop", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("midreset ready_low", 32'(req_ready_o), 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk("midreset ready_after_release", 32'(req_ready_o), 32'd1);
    chk("midreset no_done", 32'(done_cnt - d0), 32'd0);
    chk("midreset no_err", 32'(err_cnt - e0), 32'd0);
    $display("midreset: reset during WR_SUB, cyc=%0d", wb_cyc_o);
    v = '{8'd1, 32'd77, 32'd88, 1'b0, 0, 2, 1'b0, 2, 13'h0804, 13'h0A04, 1'b1};
    run_vec(v, "post_reset");

    // Back-to-back requests with valid held high.
    base = log_q.size(); d0 = done_cnt;
    ack_delay = 1;
    @(negedge wb_clk_i);
    req_valid_i = 1'b1; req_beam_i = 8'd0; req_thr_i = 32'd11; req_sub_i = 32'd22; req_apply_i = 1'b0;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    @(negedge wb_clk_i);
    req_beam_i = 8'd1; req_thr_i = 32'd33; req_sub_i = 32'd44;
    early = 0; n = 0;
    while (!done_o && n < 200) begin
      if (req_ready_o) early++;
      @(negedge wb_clk_i);
      n++;
    end
    chk("b2b first_done", 32'(done_o), 32'd1);
    chk("b2b ready_before_done", 32'(early), 32'd0);
    @(negedge wb_clk_i);
    chk("b2b ready_after_done", 32'(req_ready_o), 32'd1);
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    wait_end(200, res);
    @(negedge wb_clk_i);
    chk("b2b second outcome(1=done)", 32'(res), 32'd1);
    chk("b2b done_pulses", 32'(done_cnt - d0), 32'd2);
    n = log_q.size() - base;
    chk("b2b xact_count", 32'(n), 32'd4);
    if (n == 4) begin
      chk("b2b x2 adr", 32'(log_q[base+2].adr), 32'h0804);
      chk("b2b x2 dat", log_q[base+2].dat, 32'd33);
      chk("b2b x3 adr", 32'(log_q[base+3].adr), 32'h0A04);
      chk("b2b inter_request_gap>=1", 32'(log_q[base+2].gap >= 1), 32'd1);
    end
    $display("b2b: two requests, xacts=%0d", n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
